// File: rtl/port_array_deser_pkg.sv
// Shared types for the port-array deserializer.
package port_array_deser_pkg;

    // Control states: collecting words, or a complete array is being presented.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/port_array_deser_if.sv
// Handshake bundle of the deserializer: serial word input and parallel array output.
interface port_array_deser_if #(
    parameter int nports = 2,
    parameter int nbits  = 32
);
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_msg;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_msg [0:nports-1];

    // Producer of words / consumer of arrays.
    modport master (
        output in_val,
        output in_msg,
        output out_rdy,
        input  in_rdy,
        input  out_val,
        input  out_msg
    );

    // The deserializer itself.
    modport slave (
        input  in_val,
        input  in_msg,
        input  out_rdy,
        output in_rdy,
        output out_val,
        output out_msg
    );
endinterface

// File: rtl/port_array_deser_reg_en.sv
// Enable register used for one element of the assembled array.
module reg_en #(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [nbits-1:0] d,
    output logic [nbits-1:0] q
);

    // Capture d when enabled; cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= {nbits{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/port_array_deser.sv
// Serial-to-parallel deserializer: collects nports words and presents them as one array.
module port_array_deser
    import port_array_deser_pkg::*;
#(
    parameter int nports = 2,
    parameter int nbits  = 32
) (
    input  logic               clk,
    input  logic               reset,
    port_array_deser_if.slave  io
);

    localparam int              iw       = (nports > 1) ? $clog2(nports) : 1;
    localparam logic [iw-1:0]   idx_last = iw'(nports - 1);
    localparam logic [iw-1:0]   idx_zero = {iw{1'b0}};
    localparam logic [iw-1:0]   idx_one  = iw'(1);

    state_t              state_r;
    state_t              state_s;
    logic [iw-1:0]       idx_r;
    logic [iw-1:0]       idx_s;
    logic [iw-1:0]       wr_idx_s;
    logic                accept_s;
    logic                in_rdy_s;
    logic                out_val_s;
    logic [nports-1:0]   wr_en_s;

    // State and write-index registers; reset discards any partial or presented array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FILL;
            idx_r   <= idx_zero;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state, handshake and element-write decode.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        wr_idx_s  = idx_zero;
        accept_s  = 1'b0;
        in_rdy_s  = 1'b0;
        out_val_s = 1'b0;
        case (state_r)
            FILL: begin
                in_rdy_s = 1'b1;
                accept_s = io.in_val;
                wr_idx_s = idx_r;
                if (io.in_val) begin
                    if (idx_r == idx_last) begin
                        idx_s   = idx_zero;
                        state_s = FULL;
                    end else begin
                        idx_s   = idx_r + idx_one;
                        state_s = FILL;
                    end
                end else begin
                    idx_s   = idx_r;
                    state_s = FILL;
                end
            end
            FULL: begin
                out_val_s = 1'b1;
                // Ready follows the consumer so a new array can start in the transfer cycle.
                in_rdy_s  = io.out_rdy;
                accept_s  = io.in_val && io.out_rdy;
                wr_idx_s  = idx_zero;
                if (io.out_rdy) begin
                    if (io.in_val) begin
                        if (nports == 1) begin
                            idx_s   = idx_zero;
                            state_s = FULL;
                        end else begin
                            idx_s   = idx_one;
                            state_s = FILL;
                        end
                    end else begin
                        idx_s   = idx_zero;
                        state_s = FILL;
                    end
                end else begin
                    idx_s   = idx_r;
                    state_s = FULL;
                end
            end
            default: begin
                idx_s   = idx_zero;
                state_s = FILL;
            end
        endcase
        for (int k = 0; k < nports; k++) begin
            wr_en_s[k] = accept_s && (wr_idx_s == iw'(k));
        end
    end

    // Handshake outputs are forced low for as long as reset is held.
    always_comb begin
        if (!reset) begin
            io.in_rdy  = 1'b0;
            io.out_val = 1'b0;
        end else begin
            io.in_rdy  = in_rdy_s;
            io.out_val = out_val_s;
        end
    end

    // One enable register per array element, all loaded from the serial input.
    for (genvar g = 0; g < nports; g++) begin : g_elem
        logic [nbits-1:0] q;

        reg_en #(
            .nbits (nbits)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en_s[g]),
            .d     (io.in_msg),
            .q     (q)
        );

        assign io.out_msg[g] = q;
    end

endmodule

// File: tb/tb_port_array_deser.sv
// Self-checking bench for port_array_deser with nports = 2, 1 and 4.
module tb_port_array_deser;

    logic clk;
    logic reset;

    port_array_deser_if #(.nports(2), .nbits(32)) b2 ();
    port_array_deser_if #(.nports(1), .nbits(32)) b1 ();
    port_array_deser_if #(.nports(4), .nbits(32)) b4 ();

    port_array_deser #(.nports(2), .nbits(32)) dut2 (.clk(clk), .reset(reset), .io(b2.slave));
    port_array_deser #(.nports(1), .nbits(32)) dut1 (.clk(clk), .reset(reset), .io(b1.slave));
    port_array_deser #(.nports(4), .nbits(32)) dut4 (.clk(clk), .reset(reset), .io(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          sel         = 2;     // which instance is under test (its nports)
    int          narrays     = 0;     // arrays the model has seen transferred
    bit          last_acc;            // model: word accepted in last step
    logic [31:0] mq [$];              // model: words held for the current array

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_val();
        case (sel)
            1:       return b1.out_val;
            2:       return b2.out_val;
            default: return b4.out_val;
        endcase
    endfunction

    function automatic logic obs_rdy();
        case (sel)
            1:       return b1.in_rdy;
            2:       return b2.in_rdy;
            default: return b4.in_rdy;
        endcase
    endfunction

    function automatic logic [31:0] obs_msg(input int i);
        case (sel)
            1:       return b1.out_msg[0];
            2:       return b2.out_msg[i[0]];
            default: return b4.out_msg[i[1:0]];
        endcase
    endfunction

    task automatic drive(input bit v, input logic [31:0] m, input bit r);
        b1.in_val = 1'b0; b1.in_msg = 32'h0; b1.out_rdy = 1'b0;
        b2.in_val = 1'b0; b2.in_msg = 32'h0; b2.out_rdy = 1'b0;
        b4.in_val = 1'b0; b4.in_msg = 32'h0; b4.out_rdy = 1'b0;
        case (sel)
            1:       begin b1.in_val = v; b1.in_msg = m; b1.out_rdy = r; end
            2:       begin b2.in_val = v; b2.in_msg = m; b2.out_rdy = r; end
            default: begin b4.in_val = v; b4.in_msg = m; b4.out_rdy = r; end
        endcase
    endtask

    // One clock cycle: drive, check against the queue model, advance the model.
    task automatic step(input bit v, input logic [31:0] m, input bit r);
        bit exp_val;
        bit exp_rdy;
        @(negedge clk);
        drive(v, m, r);
        #1;
        exp_val = (mq.size() == sel);
        exp_rdy = (mq.size() < sel) || r;
        chk("out_val", {31'b0, obs_val()}, {31'b0, exp_val});
        chk("in_rdy",  {31'b0, obs_rdy()}, {31'b0, exp_rdy});
        if (exp_val) begin
            for (int i = 0; i < sel; i++) begin
                chk($sformatf("out_msg[%0d]", i), obs_msg(i), mq[i]);
            end
        end
        if (exp_val && r) begin
            for (int i = 0; i < sel; i++) void'(mq.pop_front());
            narrays++;
        end
        last_acc = v && exp_rdy;
        if (last_acc) mq.push_back(m);
        @(posedge clk);
    endtask

    // Pulse reset for one cycle with live-looking inputs; handshake must stay low, elements cleared.
    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_out_val", {31'b0, obs_val()}, 32'h0);
        chk("rst_in_rdy",  {31'b0, obs_rdy()}, 32'h0);
        for (int i = 0; i < sel; i++) chk($sformatf("rst_msg[%0d]", i), obs_msg(i), 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        mq.delete();
    endtask

    initial begin
        int sent;
        int cyc;
        int arr0;
        bit v;
        bit r;
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #2;
        for (int s = 1; s <= 4; s = s * 2) begin
            sel = s;
            chk("por_out_val", {31'b0, obs_val()}, 32'h0);
            chk("por_in_rdy",  {31'b0, obs_rdy()}, 32'h0);
            for (int i = 0; i < s; i++) chk("por_msg", obs_msg(i), 32'h0);
        end
        sel = 2;
        @(negedge clk);
        reset = 1'b1;

        // Basic pair.
        step(1'b1, 32'h11, 1'b1);
        step(1'b1, 32'h22, 1'b1);
        step(1'b0, 32'h0,  1'b1);

        // Backpressure: array held, incoming word refused until the consumer is ready.
        step(1'b1, 32'hA, 1'b0);
        step(1'b1, 32'hB, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 32'hC, 1'b0);
        step(1'b1, 32'hC, 1'b1);
        chk("bp_accept_c", {31'b0, last_acc}, 32'h1);
        step(1'b1, 32'hD, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Streaming 1..8 with no input bubble.
        arr0 = narrays;
        for (int w = 1; w <= 8; w++) step(1'b1, w[31:0], 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("stream_arrays", narrays - arr0, 32'd4);

        // Reset mid-fill discards the partial array.
        step(1'b1, 32'h55, 1'b1);
        do_reset();
        step(1'b1, 32'h66, 1'b1);
        step(1'b1, 32'h77, 1'b1);
        step(1'b0, 32'h0,  1'b1);

        // Single-element arrays every cycle.
        sel = 1;
        do_reset();
        arr0 = narrays;
        step(1'b1, 32'h1, 1'b1);
        step(1'b1, 32'h2, 1'b1);
        step(1'b1, 32'h3, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("np1_arrays", narrays - arr0, 32'd3);

        // Random traffic on the four-element instance.
        sel = 4;
        do_reset();
        arr0 = narrays;
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || mq.size() != 0) && cyc < 20000) begin
            v = (sent < 1000) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            step(v, $urandom, r);
            if (last_acc) sent++;
            cyc++;
        end
        chk("rand_words",  sent, 32'd1000);
        chk("rand_arrays", narrays - arr0, 32'd250);
        chk("rand_left",   mq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_array_deser.md
PORT_ARRAY_DESER -- requirements
Module: port_array_deser

Interface
REQ-001 SHALL have parameter nports, default 2, number of output array elements (nports >= 1).
REQ-002 SHALL have parameter nbits, default 32, width of each element.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_val  input  1  input word valid.
REQ-006 SHALL have port in_rdy  output  1  input word ready.
REQ-007 SHALL have port in_msg  input  nbits  serial input word.
REQ-008 SHALL have port out_val  output  1  output array valid.
REQ-009 SHALL have port out_rdy  input  1  output array ready.
REQ-010 SHALL have port out_msg  output  nbits x [0:nports-1] (unpacked)  assembled parallel array.

Function
REQ-011 SHALL transfer an input word only on a cycle with in_val && in_rdy, and an output array only on a cycle with out_val && out_rdy.
REQ-012 SHALL implement a two-state FSM: FILL (collecting words) and FULL (array presented).
REQ-013 SHALL keep a write index idx, width max(1,$clog2(nports)), range 0..nports-1, never exceeding nports-1.
REQ-014 In FILL: in_rdy=1, out_val=0; each accepted word is written to out_msg[idx] and idx increments.
REQ-015 In FILL, accepting a word at idx==nports-1 SHALL set idx to 0 and move to FULL.
REQ-016 In FULL: out_val=1, in_rdy=out_rdy (combinational), and out_msg SHALL be held stable until the array transfers.
REQ-017 In FULL with out_rdy=1 and in_val=1, the same-cycle input word SHALL be written to out_msg[0]; idx becomes 1 and state becomes FILL (stays FULL with idx 0 when nports==1).
REQ-018 In FULL with out_rdy=1 and in_val=0, state SHALL become FILL with idx 0.
REQ-019 out_val SHALL rise the cycle after the last element is accepted (one-cycle latency); sustained throughput SHALL be one word per cycle with no bubble between arrays.
REQ-020 Elements not yet overwritten in a new fill SHALL retain prior values; out_msg is only meaningful while out_val=1.
REQ-021 out_rdy while out_val=0 SHALL be ignored; in_msg while in_rdy=0 SHALL be ignored.
REQ-022 Element order SHALL be arrival order: first word to out_msg[0], last to out_msg[nports-1].

Reset
REQ-023 While reset=0, in_rdy and out_val SHALL both be 0, regardless of state.
REQ-024 Reset assertion SHALL immediately force state FILL, idx 0, all out_msg elements 0, discarding any partial or presented array.
REQ-025 On the first edge after reset deasserts, in_rdy=1 and out_val=0.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (FILL, FULL) and no other block-specific constants.
REQ-027 The element storage SHALL use one enable-register sub-module, reg_en, instantiated nports times in a generate loop; control SHALL live in port_array_deser.
REQ-028 The RTL SHALL contain no latches and no combinational path from in_val to in_rdy.

Verification (nports=2, nbits=32 unless stated)
REQ-029 Basic: send 0x11, 0x22 back to back, out_rdy=1 -> out_val=1 on the cycle after 0x22, out_msg={0x11,0x22}, in_rdy=1 same cycle.
REQ-030 Backpressure: fill {0xA,0xB}, out_rdy=0 for 5 cycles with in_val=1 and in_msg=0xC -> in_rdy=0, out_msg held {0xA,0xB}; out_rdy=1 -> transfer, 0xC written to element 0, idx=1.
REQ-031 Streaming: 8 words 1..8 continuous, out_rdy=1 -> 4 arrays {1,2},{3,4},{5,6},{7,8}, no idle cycle between input words.
REQ-032 Reset mid-fill: accept 0x55, assert reset for 1 cycle -> out_val=0, in_rdy=0 during reset; after reset send 0x66, 0x77 -> array {0x66,0x77}.
REQ-033 nports=1: words 0x1,0x2,0x3 with out_rdy=1 continuously -> out_val=1 from the second cycle onward, arrays {0x1},{0x2},{0x3} on consecutive cycles.
REQ-034 Random: random in_val/out_rdy, nports=4, 1000 words -> output sequence equals input sequence grouped by 4, with no loss or duplication.
